// File: rtl/step_motor_ctrl.sv
// Stepper motor sequencer: wave/full/half-step phase table, period pacing, signed position.
// Optional STEP_MOTOR_HOLD_EN: keep the coil pattern driven while idle (holding torque).
module step_motor_ctrl #(
  parameter int STEP_W   = 16,
  parameter int PERIOD_W = 16,
  parameter int POS_W    = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [STEP_W-1:0]   cmd_steps,
  input  logic                cmd_dir,
  input  logic [1:0]          cmd_mode,
  input  logic [PERIOD_W-1:0] cmd_period,
  input  logic                abort,
  output logic [3:0]          out,
  output logic                busy,
  output logic                done,
  output logic [POS_W-1:0]    position
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]          state;
  logic [STEP_W-1:0]   steps_left;
  logic [PERIOD_W-1:0] per_m1;
  logic [PERIOD_W-1:0] cnt;
  logic                dir_q;
  logic                half_q;
  logic [2:0]          idx;
  logic [2:0]          idx_inc;
  logic [3:0]          pat;
  logic                done_pend;
  logic                accept;
  logic                step_now;
  logic                last_step;

  assign busy      = (state == S_RUN);
  assign cmd_ready = !busy;
  assign accept    = cmd_valid && cmd_ready;
  assign step_now  = busy && (cnt == per_m1);
  assign last_step = step_now && (steps_left == STEP_W'(1));
  assign idx_inc   = half_q ? 3'd1 : 3'd2;

  always_comb begin
    pat = 4'b0001;
    case (idx)
      3'd0: pat = 4'b0001;
      3'd1: pat = 4'b0011;
      3'd2: pat = 4'b0010;
      3'd3: pat = 4'b0110;
      3'd4: pat = 4'b0100;
      3'd5: pat = 4'b1100;
      3'd6: pat = 4'b1000;
      3'd7: pat = 4'b1001;
      default: pat = 4'b0001;
    endcase
  end

`ifdef STEP_MOTOR_HOLD_EN
  assign out = pat;
`else
  assign out = busy ? pat : 4'b0000;
`endif

  // done is issued one cycle after the finishing event (last step, abort, or zero-step accept)
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      steps_left <= '0;
      per_m1     <= '0;
      cnt        <= '0;
      dir_q      <= 1'b0;
      half_q     <= 1'b0;
      idx        <= 3'd0;
      position   <= '0;
      done_pend  <= 1'b0;
      done       <= 1'b0;
    end else begin
      done      <= done_pend;
      done_pend <= 1'b0;
      if (accept) begin
        dir_q      <= cmd_dir;
        half_q     <= cmd_mode[1];
        per_m1     <= (cmd_period == '0) ? '0 : cmd_period - PERIOD_W'(1);
        steps_left <= cmd_steps;
        cnt        <= '0;
        case (cmd_mode)
          2'd0:    idx <= {idx[2:1], 1'b0};
          2'd1:    idx <= {idx[2:1], 1'b1};
          default: idx <= idx;
        endcase
        if (cmd_steps == '0) done_pend <= 1'b1;
        else                 state     <= S_RUN;
      end else if (busy) begin
        // abort only wins over a step that is not the final one
        if (abort && !last_step) begin
          state     <= S_IDLE;
          done_pend <= 1'b1;
        end else if (step_now) begin
          idx        <= dir_q ? idx + idx_inc : idx - idx_inc;
          position   <= dir_q ? position + POS_W'(1) : position - POS_W'(1);
          steps_left <= steps_left - STEP_W'(1);
          cnt        <= '0;
          if (last_step) begin
            state     <= S_IDLE;
            done_pend <= 1'b1;
          end
        end else begin
          cnt <= cnt + PERIOD_W'(1);
        end
      end
    end
  end

endmodule
